// File: rtl/semaphore_pkg.sv
// Shared types and default phase durations for the crossing controller.
package semaphore_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        RED     = 3'd1,
        RED_YEL = 3'd2,
        GREEN   = 3'd3,
        YELLOW  = 3'd4,
        WALK    = 3'd5,
        BLINK   = 3'd6
    } tl_state_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
        logic walk;
    } tl_lamps_t;

    localparam int DEF_W          = 8;
    localparam int DEF_T_RED      = 20;
    localparam int DEF_T_RY       = 3;
    localparam int DEF_T_GREEN    = 30;
    localparam int DEF_T_YELLOW   = 4;
    localparam int DEF_T_WALK     = 15;
    localparam int DEF_WD_CYCLES  = 1024;
    localparam int DEF_BLINK_HALF = 8;

    function automatic logic is_timed(tl_state_t s);
        return s inside {RED, RED_YEL, GREEN, YELLOW, WALK};
    endfunction

endpackage

// File: rtl/tl_watchdog.sv
// Phase watchdog: saturating cycle counter, tmo once WD_CYCLES cycles pass in a phase.
// Latency: tmo is combinational from the count register; no backpressure.
module tl_watchdog #(
    parameter int WD_CYCLES = 1024
) (
    input  logic clk,
    input  logic reset,
    input  logic clear_i,
    input  logic enable_i,
    output logic tmo_o
);

    localparam int CW = $clog2(WD_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX  = CW'(WD_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(WD_CYCLES - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i && cnt_q != CNT_MAX) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // The entry cycle holds count 0, so the last allowed cycle holds WD_CYCLES-1.
    assign tmo_o = enable_i && (cnt_q >= CNT_LAST);

endmodule

// File: rtl/traffic_light_ctrl.sv
// Road + pedestrian phase sequencer driving a start/done interval timer, with watchdog and fault blink.
// Latency: next phase and its timer_start one cycle after timer_done; no backpressure beyond the done handshake.
module traffic_light_ctrl
    import semaphore_pkg::*;
#(
    parameter int W          = DEF_W,
    parameter int T_RED      = DEF_T_RED,
    parameter int T_RY       = DEF_T_RY,
    parameter int T_GREEN    = DEF_T_GREEN,
    parameter int T_YELLOW   = DEF_T_YELLOW,
    parameter int T_WALK     = DEF_T_WALK,
    parameter int WD_CYCLES  = DEF_WD_CYCLES,
    parameter int BLINK_HALF = DEF_BLINK_HALF
) (
    input  logic         clk,
    input  logic         reset,
    output logic         timer_start,
    output logic [W-1:0] timer_load,
    input  logic         timer_done,
    input  logic         ped_req,
    input  logic         fault,
    output logic         lamp_red,
    output logic         lamp_yellow,
    output logic         lamp_green,
    output logic         ped_walk,
    output logic         wd_err
);

    if (T_RED >= 2**W || T_RY >= 2**W || T_GREEN >= 2**W ||
        T_YELLOW >= 2**W || T_WALK >= 2**W) begin : g_dur_chk
        $error("traffic_light_ctrl: a phase duration does not fit in W bits");
    end

    localparam logic [W-1:0] LD_RED    = W'(T_RED);
    localparam logic [W-1:0] LD_RY     = W'(T_RY);
    localparam logic [W-1:0] LD_GREEN  = W'(T_GREEN);
    localparam logic [W-1:0] LD_YELLOW = W'(T_YELLOW);
    localparam logic [W-1:0] LD_WALK   = W'(T_WALK);

    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);
    localparam tl_lamps_t LAMPS_RST = '{red: 1'b1, yellow: 1'b0, green: 1'b0, walk: 1'b0};

    tl_state_t     state_q, state_d;
    tl_lamps_t     lamps_q, lamps_d;
    logic          timer_start_q, timer_start_d;
    logic [W-1:0]  timer_load_q, timer_load_d;
    logic [W-1:0]  phase_load;
    logic          ped_q, ped_d;
    logic          wd_err_q, wd_err_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          enter;
    logic          wd_tmo;

    tl_watchdog #(
        .WD_CYCLES (WD_CYCLES)
    ) u_wd (
        .clk      (clk),
        .reset    (reset),
        .clear_i  (enter || !is_timed(state_q)),
        .enable_i (is_timed(state_q)),
        .tmo_o    (wd_tmo)
    );

    // Fault beats done, done beats the watchdog; done in the entry cycle belongs to the previous timer.
    always_comb begin
        state_d  = state_q;
        wd_err_d = wd_err_q;
        enter    = 1'b0;
        case (state_q)
            INIT: begin
                state_d = RED;
                enter   = 1'b1;
            end
            BLINK: begin
                if (!fault && !wd_err_q) begin
                    state_d = RED;
                    enter   = 1'b1;
                end
            end
            default: begin
                if (fault) begin
                    state_d = BLINK;
                end else if (timer_done && !timer_start_q) begin
                    enter = 1'b1;
                    case (state_q)
                        RED:     state_d = (ped_q || ped_req) ? WALK : RED_YEL;
                        WALK:    state_d = RED_YEL;
                        RED_YEL: state_d = GREEN;
                        GREEN:   state_d = YELLOW;
                        default: state_d = RED;
                    endcase
                end else if (wd_tmo) begin
                    state_d  = BLINK;
                    wd_err_d = 1'b1;
                end
            end
        endcase
    end

    always_comb begin
        lamps_d     = '0;
        phase_load  = '0;
        blink_cnt_d = '0;
        case (state_d)
            INIT:    lamps_d.red = 1'b1;
            RED:     begin lamps_d.red = 1'b1; phase_load = LD_RED; end
            RED_YEL: begin lamps_d.red = 1'b1; lamps_d.yellow = 1'b1; phase_load = LD_RY; end
            GREEN:   begin lamps_d.green = 1'b1; phase_load = LD_GREEN; end
            YELLOW:  begin lamps_d.yellow = 1'b1; phase_load = LD_YELLOW; end
            WALK:    begin lamps_d.red = 1'b1; lamps_d.walk = 1'b1; phase_load = LD_WALK; end
            BLINK: begin
                if (state_q != BLINK) begin
                    lamps_d.yellow = 1'b1;
                end else if (blink_cnt_q == BLINK_LAST) begin
                    lamps_d.yellow = ~lamps_q.yellow;
                end else begin
                    lamps_d.yellow = lamps_q.yellow;
                    blink_cnt_d    = blink_cnt_q + 1'b1;
                end
            end
            default: ;
        endcase
        timer_start_d = enter;
        timer_load_d  = enter ? phase_load : timer_load_q;
        ped_d         = (enter && state_d == WALK) ? 1'b0 : (ped_q || ped_req);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= INIT;
            lamps_q       <= LAMPS_RST;
            timer_start_q <= 1'b0;
            timer_load_q  <= '0;
            ped_q         <= 1'b0;
            wd_err_q      <= 1'b0;
            blink_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            lamps_q       <= lamps_d;
            timer_start_q <= timer_start_d;
            timer_load_q  <= timer_load_d;
            ped_q         <= ped_d;
            wd_err_q      <= wd_err_d;
            blink_cnt_q   <= blink_cnt_d;
        end
    end

    assign timer_start = timer_start_q;
    assign timer_load  = timer_load_q;
    assign lamp_red    = lamps_q.red;
    assign lamp_yellow = lamps_q.yellow;
    assign lamp_green  = lamps_q.green;
    assign ped_walk    = lamps_q.walk;
    assign wd_err      = wd_err_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Bench for traffic_light_ctrl with a start/done responder and a scoreboard of expected phase entries.
module tb_traffic_light_ctrl;

    localparam int W = 8;
    localparam logic [W-1:0] L_RED = 8'd4, L_RY = 8'd2, L_GRN = 8'd5, L_YEL = 8'd3, L_WALK = 8'd3;
    // lamp vectors are {red, yellow, green, walk}
    localparam logic [3:0] M_RED = 4'b1000, M_RY = 4'b1100, M_GRN = 4'b0010;
    localparam logic [3:0] M_YEL = 4'b0100, M_WALK = 4'b1001, M_OFF = 4'b0000;

    typedef struct packed {
        logic [W-1:0] load;
        logic [3:0]   lamps;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         timer_start;
    logic [W-1:0] timer_load;
    logic         timer_done = 1'b0;
    logic         ped_req = 1'b0;
    logic         fault = 1'b0;
    logic         lamp_red, lamp_yellow, lamp_green, ped_walk, wd_err;
    logic [3:0]   lamps;

    int   n_pass = 0;
    int   n_total = 0;
    bit   mute_yellow = 1'b0;
    exp_t exp_q[$];

    assign lamps = {lamp_red, lamp_yellow, lamp_green, ped_walk};

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .W(W), .T_RED(4), .T_RY(2), .T_GREEN(5), .T_YELLOW(3), .T_WALK(3),
        .WD_CYCLES(16), .BLINK_HALF(2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .timer_start (timer_start),
        .timer_load  (timer_load),
        .timer_done  (timer_done),
        .ped_req     (ped_req),
        .fault       (fault),
        .lamp_red    (lamp_red),
        .lamp_yellow (lamp_yellow),
        .lamp_green  (lamp_green),
        .ped_walk    (ped_walk),
        .wd_err      (wd_err)
    );

    // Interval timer model: done is high in the cycle timer_load cycles after the start cycle.
    initial begin
        int rem;
        rem = 0;
        forever begin
            @(negedge clk);
            timer_done = 1'b0;
            if (reset) begin
                rem = 0;
            end else if (timer_start) begin
                rem = (mute_yellow && lamps == M_YEL) ? 0 : int'(timer_load);
            end else if (rem > 0) begin
                rem--;
                if (rem == 0) timer_done = 1'b1;
            end
        end
    end

    function automatic void push_exp(logic [W-1:0] load, logic [3:0] m);
        exp_t e;
        e.load  = load;
        e.lamps = m;
        exp_q.push_back(e);
    endfunction

    task automatic wait_start(input int budget, output bit got, output int cycles);
        got    = 1'b0;
        cycles = 0;
        while (!got && cycles < budget) begin
            @(negedge clk);
            cycles++;
            if (timer_start === 1'b1) got = 1'b1;
        end
    endtask

    task automatic test_reset();
        bit got;
        int cyc;
        int prev;
        exp_t e;
        reset = 1'b1;
        repeat (2) @(negedge clk);
        n_total++;
        if ({timer_start, timer_load, lamps, wd_err} !== {1'b0, 8'd0, M_RED, 1'b0}) begin
            $display("FAIL reset_state: got start/load/lamps/wd=%b/%0d/%b/%b want 0/0/1000/0",
                     timer_start, timer_load, lamps, wd_err);
        end else n_pass++;
        reset = 1'b0;
        push_exp(L_RED, M_RED); push_exp(L_RY, M_RY); push_exp(L_GRN, M_GRN);
        push_exp(L_YEL, M_YEL); push_exp(L_RED, M_RED);
        prev = 0;
        for (int i = 0; i < 5; i++) begin
            wait_start(64, got, cyc);
            e = exp_q.pop_front();
            n_total++;
            if (!got) begin
                $display("FAIL full_cycle[%0d]: no timer_start within budget, want load %0d", i, e.load);
            end else if ({timer_load, lamps} !== e) begin
                $display("FAIL full_cycle[%0d]: got load=%0d lamps=%b want load=%0d lamps=%b",
                         i, timer_load, lamps, e.load, e.lamps);
            end else n_pass++;
            // one start per phase, no gap: next start lands load+1 cycles later
            n_total++;
            if (cyc !== ((i == 0) ? 1 : prev + 1)) begin
                $display("FAIL start_spacing[%0d]: got %0d cycles want %0d", i, cyc, (i == 0) ? 1 : prev + 1);
            end else n_pass++;
            prev = int'(e.load);
        end
    endtask

    task automatic test_ped_walk();
        bit got;
        int cyc;
        exp_t e;
        push_exp(L_RY, M_RY); push_exp(L_GRN, M_GRN);
        for (int i = 0; i < 2; i++) begin
            wait_start(64, got, cyc);
            e = exp_q.pop_front();
            n_total++;
            if (!got || {timer_load, lamps} !== e) begin
                $display("FAIL ped_pre[%0d]: got start=%b load=%0d lamps=%b want load=%0d lamps=%b",
                         i, got, timer_load, lamps, e.load, e.lamps);
            end else n_pass++;
        end
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        push_exp(L_YEL, M_YEL); push_exp(L_RED, M_RED); push_exp(L_WALK, M_WALK);
        push_exp(L_RY, M_RY); push_exp(L_GRN, M_GRN); push_exp(L_YEL, M_YEL);
        push_exp(L_RED, M_RED); push_exp(L_RY, M_RY);
        for (int i = 0; i < 8; i++) begin
            wait_start(64, got, cyc);
            e = exp_q.pop_front();
            n_total++;
            if (!got || {timer_load, lamps} !== e) begin
                $display("FAIL ped_walk[%0d]: got start=%b load=%0d lamps=%b want load=%0d lamps=%b",
                         i, got, timer_load, lamps, e.load, e.lamps);
            end else n_pass++;
        end
    endtask

    task automatic test_ped_at_done();
        bit got;
        int cyc;
        exp_t e;
        push_exp(L_GRN, M_GRN); push_exp(L_YEL, M_YEL); push_exp(L_RED, M_RED);
        for (int i = 0; i < 3; i++) begin
            wait_start(64, got, cyc);
            e = exp_q.pop_front();
            n_total++;
            if (!got || {timer_load, lamps} !== e) begin
                $display("FAIL ped_done_pre[%0d]: got start=%b load=%0d lamps=%b want load=%0d lamps=%b",
                         i, got, timer_load, lamps, e.load, e.lamps);
            end else n_pass++;
        end
        repeat (4) @(negedge clk);
        ped_req = 1'b1;
        n_total++;
        if ({timer_start, lamps} !== {1'b0, M_RED}) begin
            $display("FAIL ped_done_red: got start=%b lamps=%b want 0/1000", timer_start, lamps);
        end else n_pass++;
        push_exp(L_WALK, M_WALK);
        @(negedge clk);
        ped_req = 1'b0;
        e = exp_q.pop_front();
        n_total++;
        if ({timer_start, timer_load, lamps} !== {1'b1, e}) begin
            $display("FAIL ped_done_walk: got start=%b load=%0d lamps=%b want 1/%0d/%b",
                     timer_start, timer_load, lamps, e.load, e.lamps);
        end else n_pass++;
        push_exp(L_RY, M_RY);
        wait_start(64, got, cyc);
        e = exp_q.pop_front();
        n_total++;
        if (!got || {timer_load, lamps} !== e) begin
            $display("FAIL ped_done_post: got start=%b load=%0d lamps=%b want load=%0d lamps=%b",
                     got, timer_load, lamps, e.load, e.lamps);
        end else n_pass++;
    endtask

    task automatic test_fault_blink();
        bit got;
        int cyc;
        exp_t e;
        push_exp(L_GRN, M_GRN);
        wait_start(64, got, cyc);
        e = exp_q.pop_front();
        n_total++;
        if (!got || {timer_load, lamps} !== e) begin
            $display("FAIL fault_green: got start=%b load=%0d lamps=%b want load=%0d lamps=%b",
                     got, timer_load, lamps, e.load, e.lamps);
        end else n_pass++;
        repeat (2) @(negedge clk);
        fault = 1'b1;
        for (int i = 0; i < 10; i++) push_exp(8'd0, ((i / 2) % 2 == 0) ? M_YEL : M_OFF);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_total++;
            if ({timer_start, lamps} !== {1'b0, e.lamps}) begin
                $display("FAIL fault_blink[%0d]: got start=%b lamps=%b want 0/%b", i, timer_start, lamps, e.lamps);
            end else n_pass++;
        end
        fault = 1'b0;
        @(negedge clk);
        n_total++;
        if ({timer_start, timer_load, lamps, wd_err} !== {1'b1, L_RED, M_RED, 1'b0}) begin
            $display("FAIL fault_exit: got start=%b load=%0d lamps=%b wd=%b want 1/4/1000/0",
                     timer_start, timer_load, lamps, wd_err);
        end else n_pass++;
    endtask

    task automatic test_watchdog();
        bit got;
        int cyc;
        exp_t e;
        mute_yellow = 1'b1;
        push_exp(L_RY, M_RY); push_exp(L_GRN, M_GRN); push_exp(L_YEL, M_YEL);
        for (int i = 0; i < 3; i++) begin
            wait_start(64, got, cyc);
            e = exp_q.pop_front();
            n_total++;
            if (!got || {timer_load, lamps} !== e) begin
                $display("FAIL wd_pre[%0d]: got start=%b load=%0d lamps=%b want load=%0d lamps=%b",
                         i, got, timer_load, lamps, e.load, e.lamps);
            end else n_pass++;
        end
        repeat (15) @(negedge clk);
        n_total++;
        if ({wd_err, lamps} !== {1'b0, M_YEL}) begin
            $display("FAIL wd_last_yellow: got wd=%b lamps=%b want 0/0100", wd_err, lamps);
        end else n_pass++;
        for (int i = 0; i < 20; i++) push_exp(8'd0, ((i / 2) % 2 == 0) ? M_YEL : M_OFF);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            e = exp_q.pop_front();
            n_total++;
            if ({wd_err, timer_start, lamps} !== {1'b1, 1'b0, e.lamps}) begin
                $display("FAIL wd_blink[%0d]: got wd=%b start=%b lamps=%b want 1/0/%b",
                         i, wd_err, timer_start, lamps, e.lamps);
            end else n_pass++;
        end
        reset = 1'b1;
        mute_yellow = 1'b0;
        @(negedge clk);
        n_total++;
        if ({wd_err, timer_start, lamps} !== {1'b0, 1'b0, M_RED}) begin
            $display("FAIL wd_reset: got wd=%b start=%b lamps=%b want 0/0/1000", wd_err, timer_start, lamps);
        end else n_pass++;
    endtask

    task automatic test_reset_mid_phase();
        bit got;
        int cyc;
        exp_t e;
        reset = 1'b0;
        push_exp(L_RED, M_RED); push_exp(L_WALK, M_WALK); push_exp(L_RY, M_RY);
        for (int i = 0; i < 3; i++) begin
            wait_start(64, got, cyc);
            e = exp_q.pop_front();
            n_total++;
            if (!got || {timer_load, lamps} !== e) begin
                $display("FAIL rst_pre[%0d]: got start=%b load=%0d lamps=%b want load=%0d lamps=%b",
                         i, got, timer_load, lamps, e.load, e.lamps);
            end else n_pass++;
            // in RED and again in the WALK entry cycle: WALK re-arms the pending request
            if (i < 2) begin
                ped_req = 1'b1;
                @(negedge clk);
                ped_req = 1'b0;
            end
        end
        reset = 1'b1;
        @(negedge clk);
        n_total++;
        if ({timer_start, timer_load, lamps} !== {1'b0, 8'd0, M_RED}) begin
            $display("FAIL rst_mid: got start=%b load=%0d lamps=%b want 0/0/1000", timer_start, timer_load, lamps);
        end else n_pass++;
        reset = 1'b0;
        push_exp(L_RED, M_RED); push_exp(L_RY, M_RY);
        for (int i = 0; i < 2; i++) begin
            wait_start(64, got, cyc);
            e = exp_q.pop_front();
            n_total++;
            if (!got || {timer_load, lamps} !== e) begin
                $display("FAIL rst_post[%0d]: got start=%b load=%0d lamps=%b want load=%0d lamps=%b",
                         i, got, timer_load, lamps, e.load, e.lamps);
            end else n_pass++;
        end
    endtask

    initial begin
        test_reset();
        test_ped_walk();
        test_ped_at_done();
        test_fault_blink();
        test_watchdog();
        test_reset_mid_phase();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
